// File: rtl/codec_config_sequencer.sv
// Codec configuration sequencer: after a power-up delay walks the init table one SPI word per
// entry, then arbitrates run-time single-word writes onto the same 16-bit SPI shifter.
module codec_config_sequencer #(
  parameter int DATASIZE       = 16,
  parameter int NWORDS         = 11,
  parameter int ADDRW          = 4,
  parameter int STARTUP_CYCLES = 1024,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [DATASIZE-1:0] SPI_DATA,
  output logic                SPI_TRG,
  input  logic                SPI_RDY,
  output logic [ADDRW-1:0]    TBL_ADDR,
  input  logic [DATASIZE-1:0] TBL_DATA,
  input  logic                START,
  input  logic                WR_REQ,
  input  logic [DATASIZE-1:0] WR_DATA,
  output logic                WR_ACK,
  output logic                INIT_DONE,
  output logic                BUSY
);

  localparam logic [15:0]      STARTUP_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [7:0]       GAP_LAST     = 8'(GAP_CYCLES - 1);
  localparam logic [ADDRW-1:0] LAST_ADDR    = ADDRW'(NWORDS - 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_GAP,
    ST_IDLE
  } state_t;

  state_t              state_q,     state_d;
  logic [15:0]         start_cnt_q, start_cnt_d;
  logic [7:0]          gap_cnt_q,   gap_cnt_d;
  logic [DATASIZE-1:0] spi_data_q,  spi_data_d;
  logic                spi_trg_q,   spi_trg_d;
  logic [ADDRW-1:0]    tbl_addr_q,  tbl_addr_d;
  logic                wr_ack_q,    wr_ack_d;
  logic                init_done_q, init_done_d;
  logic                src_wr_q,    src_wr_d;
  logic [DATASIZE-1:0] wr_data_q,   wr_data_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_STARTUP;
      start_cnt_q <= '0;
      gap_cnt_q   <= '0;
      spi_data_q  <= '0;
      spi_trg_q   <= 1'b0;
      tbl_addr_q  <= '0;
      wr_ack_q    <= 1'b0;
      init_done_q <= 1'b0;
      src_wr_q    <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_data_q  <= spi_data_d;
      spi_trg_q   <= spi_trg_d;
      tbl_addr_q  <= tbl_addr_d;
      wr_ack_q    <= wr_ack_d;
      init_done_q <= init_done_d;
      src_wr_q    <= src_wr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    spi_data_d  = spi_data_q;
    spi_trg_d   = 1'b0;
    tbl_addr_d  = tbl_addr_q;
    wr_ack_d    = 1'b0;
    init_done_d = init_done_q;
    src_wr_d    = src_wr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      ST_STARTUP: begin
        // Counter saturates; only a fresh reset brings the delay back.
        if (start_cnt_q >= STARTUP_LAST) begin
          if (SPI_RDY) begin
            state_d = ST_FETCH;
          end
        end else begin
          start_cnt_d = start_cnt_q + 16'd1;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        spi_data_d = src_wr_q ? wr_data_q : TBL_DATA;
        spi_trg_d  = 1'b1;
        state_d    = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!SPI_RDY) begin
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (SPI_RDY) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (src_wr_q) begin
            state_d = ST_IDLE;
          end else if (tbl_addr_q == LAST_ADDR) begin
            init_done_d = 1'b1;
            tbl_addr_d  = '0;
            state_d     = ST_IDLE;
          end else begin
            tbl_addr_d = tbl_addr_q + ADDRW'(1);
            state_d    = ST_FETCH;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        // A re-run request outranks a pending write; the write waits for the next idle.
        if (START) begin
          init_done_d = 1'b0;
          tbl_addr_d  = '0;
          src_wr_d    = 1'b0;
          state_d     = ST_FETCH;
        end else if (WR_REQ) begin
          wr_data_d = WR_DATA;
          wr_ack_d  = 1'b1;
          src_wr_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_STARTUP;
      end
    endcase
  end

  assign SPI_DATA  = spi_data_q;
  assign SPI_TRG   = spi_trg_q;
  assign TBL_ADDR  = tbl_addr_q;
  assign WR_ACK    = wr_ack_q;
  assign INIT_DONE = init_done_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Self-checking bench: shifter model, protocol monitor, vector table plus random run-time traffic.
module tb_codec_config_sequencer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NW = 3;
  localparam int SU = 16;
  localparam int GP = 4;

  typedef struct {
    bit          start;
    bit          wr;
    logic [15:0] wdata;
    int          extra;
    int          exp_words;
    int          exp_acks;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] spi_data;
  logic          spi_trg;
  logic          spi_rdy;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic          start;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          init_done;
  logic          busy;

  logic [15:0] init_tab [0:NW-1] = '{16'h1E00, 16'h0C00, 16'h1201};
  logic [15:0] rom      [0:15];

  int total = 0;
  int bad   = 0;

  codec_config_sequencer #(
    .DATASIZE(DW), .NWORDS(NW), .ADDRW(AW), .STARTUP_CYCLES(SU), .GAP_CYCLES(GP)
  ) dut (
    .CLK(clk), .RESET(rst_n), .SPI_DATA(spi_data), .SPI_TRG(spi_trg), .SPI_RDY(spi_rdy),
    .TBL_ADDR(tbl_addr), .TBL_DATA(tbl_data), .START(start), .WR_REQ(wr_req),
    .WR_DATA(wr_data), .WR_ACK(wr_ack), .INIT_DONE(init_done), .BUSY(busy)
  );

  assign tbl_data = rom[tbl_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter: accepts a trigger while idle, stays busy 16+xfer_extra cycles.
  int xfer_extra = 0;
  int sh_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_rdy <= 1'b1;
      sh_cnt  <= 0;
    end else if (spi_rdy && spi_trg) begin
      spi_rdy <= 1'b0;
      sh_cnt  <= 16 + xfer_extra;
    end else if (!spi_rdy) begin
      if (sh_cnt <= 1) spi_rdy <= 1'b1;
      sh_cnt <= sh_cnt - 1;
    end
  end

  // Monitor: logs triggered words and counts protocol violations.
  int          cyc = 0;
  int          obs_n = 0;
  logic [15:0] obs_mem [0:511];
  int          obs_cyc [0:511];
  int          ack_n = 0;
  int          last_rise = -1000;
  logic        prev_trg = 1'b0, prev_rdy = 1'b1, prev_ack = 1'b0, held = 1'b0;
  logic [15:0] held_data = '0;
  int v_trg_rdy = 0, v_consec = 0, v_space = 0, v_stable = 0, v_ack_wide = 0, v_ack_early = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc       <= 0;
      prev_trg  <= 1'b0;
      prev_rdy  <= 1'b1;
      prev_ack  <= 1'b0;
      held      <= 1'b0;
      last_rise <= -1000;
    end else begin
      cyc      <= cyc + 1;
      prev_trg <= spi_trg;
      prev_rdy <= spi_rdy;
      prev_ack <= wr_ack;
      if (spi_rdy && !prev_rdy) last_rise <= cyc + 1;
      if (spi_trg) begin
        if (obs_n < 511) begin
          obs_mem[obs_n] <= spi_data;
          obs_cyc[obs_n] <= cyc + 1;
          obs_n          <= obs_n + 1;
        end
        if (!spi_rdy) v_trg_rdy <= v_trg_rdy + 1;
        if (prev_trg) v_consec <= v_consec + 1;
        if (cyc + 1 - last_rise < GP + 2) v_space <= v_space + 1;
        held      <= 1'b1;
        held_data <= spi_data;
      end else if (held) begin
        if (spi_data != held_data) v_stable <= v_stable + 1;
        if (spi_rdy && !prev_rdy) held <= 1'b0;
      end
      if (wr_ack) begin
        ack_n <= ack_n + 1;
        if (prev_ack)   v_ack_wide  <= v_ack_wide + 1;
        if (!init_done) v_ack_early <= v_ack_early + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_spi_trg"},   32'(spi_trg),   32'd0);
    chk({tag, "_spi_data"},  32'(spi_data),  32'd0);
    chk({tag, "_tbl_addr"},  32'(tbl_addr),  32'd0);
    chk({tag, "_wr_ack"},    32'(wr_ack),    32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd1);
  endtask

  // Reference model: a (re)start emits the whole table, a write follows as one word.
  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] exp_q[$];
    int base, a0, c0, b;
    exp_q = {};
    if (v.start) for (int i = 0; i < NW; i++) exp_q.push_back(init_tab[i]);
    if (v.wr) exp_q.push_back(v.wdata);
    base = obs_n;
    a0   = ack_n;
    xfer_extra = v.extra;
    step();
    start   = v.start;
    wr_req  = v.wr;
    wr_data = v.wdata;
    c0 = cyc;
    b  = 0;
    do begin
      step();
      b++;
      if (wr_ack) wr_req = 1'b0;
      if (start && !init_done) start = 1'b0;
    end while (b < 3000 && !(!start && !wr_req && !busy && obs_n >= base + exp_q.size()));
    chk({tag, "_timeout"}, 32'(b < 3000), 32'd1);
    chk({tag, "_nwords"}, 32'(obs_n - base), 32'(v.exp_words));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_word"}, 32'(obs_mem[(base + i) % 512]), 32'(exp_q[i]));
    chk({tag, "_acks"}, 32'(ack_n - a0), 32'(v.exp_acks));
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    if (v.start && obs_n > base)
      chk({tag, "_restart_latency"}, 32'(obs_cyc[base] - c0 <= 4), 32'd1);
    $display("vec %s start=%0d wr=%0d wdata=%04h extra=%0d words=%0d acks=%0d",
             tag, v.start, v.wr, v.wdata, v.extra, obs_n - base, ack_n - a0);
  endtask

  vec_t vecs [0:4];

  initial begin
    int base, a0, b;
    vec_t rv;

    vecs[0] = '{start: 1'b0, wr: 1'b1, wdata: 16'h1111, extra: 0,  exp_words: 1, exp_acks: 1};
    vecs[1] = '{start: 1'b1, wr: 1'b0, wdata: 16'h0000, extra: 0,  exp_words: 3, exp_acks: 0};
    vecs[2] = '{start: 1'b1, wr: 1'b1, wdata: 16'h0A0A, extra: 0,  exp_words: 4, exp_acks: 1};
    vecs[3] = '{start: 1'b0, wr: 1'b1, wdata: 16'h2222, extra: 50, exp_words: 1, exp_acks: 1};
    vecs[4] = '{start: 1'b1, wr: 1'b0, wdata: 16'h0000, extra: 50, exp_words: 3, exp_acks: 0};

    for (int i = 0; i < 16; i++) begin
      rom[i] = 16'h0000;
      if (i < NW) rom[i] = init_tab[i];
    end

    rst_n = 1'b0; start = 1'b0; wr_req = 1'b0; wr_data = '0;
    step();
    step();
    chk_reset_outputs("reset");

    // Power-up sequence
    rst_n = 1'b1;
    base = obs_n;
    b = 0;
    while (!(obs_n >= base + NW && !busy) && b < 1000) begin step(); b++; end
    chk("init_timeout", 32'(b < 1000), 32'd1);
    for (int i = 0; i < NW; i++) chk("init_word", 32'(obs_mem[base + i]), 32'(init_tab[i]));
    chk("startup_delay", 32'(obs_cyc[base] >= SU && obs_cyc[base] <= SU + 3), 32'd1);
    chk("init_done_after", 32'(init_done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    $display("init: %0d words, first trigger at cycle %0d", obs_n - base, obs_cyc[base]);

    // Single run-time write with exact ack-to-trigger timing
    base = obs_n; a0 = ack_n;
    wr_data = 16'h0479; wr_req = 1'b1;
    b = 0;
    while (!wr_ack && b < 200) begin step(); b++; end
    chk("wr_ack_seen", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    chk("trg_at_ack", 32'(spi_trg), 32'd0);
    step();
    chk("trg_after_ack", 32'(spi_trg), 32'd1);
    chk("data_after_ack", 32'(spi_data), 32'h0479);
    b = 0;
    while (busy && b < 500) begin step(); b++; end
    chk("wr_back_idle", 32'(busy), 32'd0);
    chk("wr_init_done", 32'(init_done), 32'd1);
    chk("wr_ack_count", 32'(ack_n - a0), 32'd1);
    chk("wr_word_count", 32'(obs_n - base), 32'd1);
    $display("write 0479: acks=%0d words=%0d", ack_n - a0, obs_n - base);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("tab%0d", i));

    // Long transfer: block must sit in WAIT_HIGH without retriggering
    xfer_extra = 50;
    base = obs_n;
    wr_data = 16'h3C3C; wr_req = 1'b1;
    b = 0;
    while (!wr_ack && b < 200) begin step(); b++; end
    wr_req = 1'b0;
    while (obs_n == base && b < 400) begin step(); b++; end
    repeat (40) step();
    chk("long_busy", 32'(busy), 32'd1);
    chk("long_no_retrig", 32'(obs_n - base), 32'd1);
    chk("long_data_held", 32'(spi_data), 32'h3C3C);
    b = 0;
    while (busy && b < 500) begin step(); b++; end
    chk("long_back_idle", 32'(busy), 32'd0);
    $display("long transfer: words=%0d", obs_n - base);

    // Random run-time traffic
    for (int i = 0; i < 20; i++) begin
      rv.start     = 1'($urandom_range(0, 1));
      rv.wr        = 1'($urandom_range(0, 1));
      rv.wdata     = 16'($urandom);
      rv.extra     = int'($urandom_range(0, 6));
      rv.exp_words = (rv.start ? NW : 0) + (rv.wr ? 1 : 0);
      rv.exp_acks  = rv.wr ? 1 : 0;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Reset mid-transfer with a write pending from the startup phase
    xfer_extra = 0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    base = obs_n; a0 = ack_n;
    repeat (5) step();
    wr_data = 16'h0A05; wr_req = 1'b1;
    b = 0;
    while (obs_n < base + 2 && b < 400) begin step(); b++; end
    chk("pre_rst_word0", 32'(obs_mem[base]), 32'h1E00);
    chk("pre_rst_word1", 32'(obs_mem[base + 1]), 32'h0C00);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    base = obs_n;
    b = 0;
    while (!(!wr_req && !busy && obs_n >= base + NW + 1) && b < 1000) begin
      step();
      b++;
      if (wr_ack) wr_req = 1'b0;
    end
    chk("rst_seq_timeout", 32'(b < 1000), 32'd1);
    for (int i = 0; i < NW; i++) chk("rst_seq_word", 32'(obs_mem[base + i]), 32'(init_tab[i]));
    chk("rst_seq_write", 32'(obs_mem[base + NW]), 32'h0A05);
    chk("rst_startup_delay", 32'(obs_cyc[base] >= SU && obs_cyc[base] <= SU + 3), 32'd1);
    chk("rst_ack_count", 32'(ack_n - a0), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd1);
    $display("reset restart: words=%0d acks=%0d", obs_n - base, ack_n - a0);

    chk("trg_while_rdy_low", 32'(v_trg_rdy), 32'd0);
    chk("trg_consecutive", 32'(v_consec), 32'd0);
    chk("trg_spacing", 32'(v_space), 32'd0);
    chk("data_stability", 32'(v_stable), 32'd0);
    chk("ack_width", 32'(v_ack_wide), 32'd0);
    chk("ack_before_init", 32'(v_ack_early), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
